// File: rtl/axis_pkg.sv
// Shared AXI-Stream types and widths for the slave FIFO stage.
package axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int PKT_CNT_W   = 16;

  typedef struct packed {
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;
  } axis_beat_t;
endpackage

// File: rtl/axis_s_fifo_mem.sv
// DEPTH x (DATA_W+1) register array: synchronous write, asynchronous read.
module axis_s_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W:0]   rdata
);
  // Storage is intentionally not reset; validity is tracked by the level count.
  logic [DATA_W:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/axis_s_fifo.sv
// AXI-Stream slave into a show-ahead FIFO with level and packet-done reporting.
// Optional 16-bit packet counter port enabled by defining AXIS_S_PKT_CNT_EN.
module axis_s_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              tvalid,
  output logic              tready,
  input  logic              tlast,
  input  logic [DATA_W-1:0] tdata,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              pkt_done
`ifdef AXIS_S_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_cnt
`endif
);
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              pkt_done_q, pkt_done_d;
  logic              wr_fire, rd_fire;
  logic [DATA_W:0]   rd_word;

  // Flow control depends only on registered state, so a read never frees
  // a slot for a write in the same cycle.
  assign full     = (level_q == (ADDR_W+1)'(DEPTH));
  assign tready   = ~full;
  assign rd_valid = (level_q != '0);
  assign wr_fire  = tvalid & tready;
  assign rd_fire  = rd_en & rd_valid;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + ADDR_W'(wr_fire);
    rd_ptr_d   = rd_ptr_q + ADDR_W'(rd_fire);
    pkt_done_d = wr_fire & tlast;
    level_d    = level_q;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  axis_s_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (aclk),
    .we    (wr_fire),
    .waddr (wr_ptr_q),
    .wdata ({tlast, tdata}),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign rd_last  = rd_word[DATA_W];
  assign rd_data  = rd_word[DATA_W-1:0];
  assign level    = level_q;
  assign pkt_done = pkt_done_q;

`ifdef AXIS_S_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(wr_fire & tlast);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) pkt_cnt_q <= '0;
    else           pkt_cnt_q <= pkt_cnt_d;
  end

  assign pkt_cnt = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_axis_s_fifo.sv
// Directed + randomized bench for axis_s_fifo against a queue-based model.
module tb_axis_s_fifo;
  import axis_pkg::*;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          tvalid = 1'b0, tlast = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tready, rd_valid, rd_last, full, pkt_done;
  logic [DW-1:0] rd_data;
  logic [AW:0]   level;
`ifdef AXIS_S_PKT_CNT_EN
  logic [15:0]   pkt_cnt;
`endif

  axis_s_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .tvalid(tvalid), .tready(tready), .tlast(tlast), .tdata(tdata),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .level(level), .full(full), .pkt_done(pkt_done)
`ifdef AXIS_S_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  // Reference model: contents as a queue, packet bookkeeping as plain counters.
  axis_beat_t q[$];
  bit         m_done;
  logic [15:0] m_cnt;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("tready",   {63'd0, tready},   {63'd0, q.size() < DEPTH});
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, q.size() != 0});
    chk("level",    64'(level),        64'(q.size()));
    chk("full",     {63'd0, full},     {63'd0, q.size() == DEPTH});
    chk("pkt_done", {63'd0, pkt_done}, {63'd0, m_done});
    if (q.size() != 0) begin
      chk("rd_data", 64'(rd_data),       64'(q[0].data));
      chk("rd_last", {63'd0, rd_last},   {63'd0, q[0].last});
    end
`ifdef AXIS_S_PKT_CNT_EN
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
`endif
  endtask

  function automatic void model_reset();
    q.delete();
    m_done = 1'b0;
    m_cnt  = '0;
  endfunction

  // One clock: drive after negedge, model the edge, check #1 after posedge.
  task automatic step(input bit tv, input bit tl, input logic [31:0] td, input bit re,
                      input bit c, output bit acc);
    bit pop;
    tvalid = tv; tlast = tl; tdata = td; rd_en = re;
    acc = tv && (q.size() < DEPTH);
    pop = re && (q.size() > 0);
    @(posedge aclk);
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{last: tl, data: td});
    m_done = acc && tl;
    if (m_done) m_cnt = m_cnt + 16'd1;
    #1;
    if (c) check_all();
    @(negedge aclk);
  endtask

  initial begin
    bit a;
    bit tv, tl;
    logic [31:0] td;
    model_reset();

    // Reset state while asserted, then idle after release
    #1;
    check_all();
    @(negedge aclk);
    areset_n = 1'b1;
    step(0, 0, 0, 0, 1, a);

    // Single-beat packet
    step(1, 1, 32'hDEADBEEF, 0, 1, a);
    step(0, 0, 0, 0, 1, a);
    step(0, 0, 0, 1, 1, a);

    // Fill to full, hold 0x5 through a full cycle, a read, then acceptance
    for (int i = 1; i <= 4; i++) step(1, 0, 32'(i), 0, 1, a);
    step(1, 0, 32'h5, 0, 1, a);
    chk("held_not_acc", {63'd0, a}, 64'd0);
    step(1, 0, 32'h5, 1, 1, a);
    chk("full_read_no_acc", {63'd0, a}, 64'd0);
    step(1, 0, 32'h5, 0, 1, a);
    chk("acc_after_free", {63'd0, a}, 64'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("order", 64'(rd_data), 64'(i));
      step(0, 0, 0, 1, 1, a);
    end

    // Simultaneous write/read at level 2; pointers wrap
    step(1, 0, 32'hA0, 0, 1, a);
    step(1, 0, 32'hA1, 0, 1, a);
    for (int i = 0; i < 10; i++) begin
      step(1, (i % 3) == 0, $urandom, 1, 1, a);
      chk("level_hold2", 64'(level), 64'd2);
    end
    step(0, 0, 0, 1, 1, a);
    step(0, 0, 0, 1, 1, a);

    // Reads while empty are ignored
    step(0, 0, 0, 1, 1, a);
    step(0, 0, 0, 1, 1, a);
    step(1, 1, 32'h1234_5678, 1, 1, a);
    step(0, 0, 0, 1, 1, a);

    // Randomized traffic honoring the AXIS hold rule
    tv = 0; tl = 0; td = 0; a = 0;
    for (int i = 0; i < 300; i++) begin
      if (!tv || a) begin
        tv = ($urandom_range(0, 3) != 0);
        tl = ($urandom_range(0, 3) == 0);
        td = $urandom;
      end
      step(tv, tl, td, $urandom_range(0, 2) == 0, 1, a);
    end
    while (q.size() != 0) step(0, 0, 0, 1, 1, a);

    // Asynchronous reset mid-stream at level 3
    for (int i = 0; i < 3; i++) step(1, 0, $urandom, 0, 1, a);
    #2 areset_n = 1'b0;
    #1;
    chk("rst_level",    64'(level),        64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_tready",   {63'd0, tready},   64'd1);
    chk("rst_full",     {63'd0, full},     64'd0);
    chk("rst_pkt_done", {63'd0, pkt_done}, 64'd0);
    model_reset();
    @(negedge aclk);
    areset_n = 1'b1;
    step(0, 0, 0, 0, 1, a);
    step(1, 1, 32'hCAFE_F00D, 0, 1, a);
    step(0, 0, 0, 1, 1, a);

`ifdef AXIS_S_PKT_CNT_EN
    // Counter wrap: bring to 0xFFFF, one more packet rolls to 0
    for (int i = 0; i < 65534; i++) step(1, 1, 32'(i), 1, 0, a);
    step(0, 0, 0, 1, 1, a);
    chk("cnt_ffff", 64'(pkt_cnt), 64'hFFFF);
    step(1, 1, 32'h77, 0, 1, a);
    chk("cnt_wrap", 64'(pkt_cnt), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
